// File: rtl/inst_align_pkg.sv
// Shared types for the instruction aligner: parcel width, decoded length codes
// and the parcel count helper used by both the RTL and its decoder sub-block.
package inst_align_pkg;

  localparam int PARCEL_W = 16;

  typedef enum logic [1:0] {
    LEN16 = 2'd0,
    LEN32 = 2'd1,
    LEN64 = 2'd2
  } len_e;

  function automatic logic [2:0] parcels_of(len_e len);
    logic [2:0] n;
    case (len)
      LEN16:   n = 3'd1;
      LEN32:   n = 3'd2;
      LEN64:   n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  // Parcel k of a big-endian fetch word; parcel 0 is the most significant.
  function automatic logic [PARCEL_W-1:0] word_parcel(logic [63:0] w, int k);
    return w[63-16*k -: 16];
  endfunction

endpackage

// File: rtl/inst_align_if.sv
// Fetch-side and decode-side handshake bundle of the instruction aligner.
interface inst_align_if;
  logic [63:0] fetch_data;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        flush;
  logic [63:0] flush_pc;
  logic [63:0] inst_data;
  logic [1:0]  inst_len;
  logic [63:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [4:0]  fill_level;

  modport slave (
    input  fetch_data, fetch_valid, flush, flush_pc, inst_ready,
    output fetch_ready, inst_data, inst_len, inst_pc, inst_valid, fill_level
  );

  modport master (
    output fetch_data, fetch_valid, flush, flush_pc, inst_ready,
    input  fetch_ready, inst_data, inst_len, inst_pc, inst_valid, fill_level
  );
endinterface

// File: rtl/inst_align_len_decode.sv
// Combinational length decode of the head parcel: top two bits select 16/32/64b.
module inst_len_decode
  import inst_align_pkg::*;
(
  input  logic [PARCEL_W-1:0] parcel,
  output len_e                len,
  output logic [2:0]          n_parcels
);

  always_comb begin
    len = LEN16;
    case (parcel[15:14])
      2'b10:   len = LEN32;
      2'b11:   len = LEN64;
      default: len = LEN16;
    endcase
    n_parcels = parcels_of(len);
  end

endmodule

// File: rtl/inst_align.sv
// Instruction aligner: buffers fetch words as 16-bit parcels and presents one
// left-justified, length-tagged instruction per cycle with its PC.
module inst_align
  import inst_align_pkg::*;
#(
  parameter int DEPTH = 12
) (
  input  logic        clk,
  input  logic        rst,
  inst_align_if.slave bus
);

  logic [PARCEL_W-1:0] buf_q [DEPTH];
  logic [PARCEL_W-1:0] buf_d [DEPTH];
  logic [4:0]          count_q, count_d;
  logic [1:0]          skip_q, skip_d;
  logic [63:0]         pc_q, pc_d;

  len_e        head_len;
  logic [2:0]  head_n;
  logic        valid_s;
  logic        ready_s;
  logic        enq_s;
  logic        deq_s;
  logic [63:0] data_s;

  inst_len_decode u_len_decode (
    .parcel    (buf_q[0]),
    .len       (head_len),
    .n_parcels (head_n)
  );

  assign valid_s = (count_q >= {2'b00, head_n});
  assign ready_s = !rst && (count_q <= 5'(DEPTH - 4));
  assign enq_s   = bus.fetch_valid && ready_s;
  assign deq_s   = valid_s && bus.inst_ready && !rst;

  // Only parcels that belong to the head instruction and are actually held are shown.
  always_comb begin
    data_s = 64'd0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(head_n) && i < int'(count_q)) begin
        data_s[63-16*i -: 16] = buf_q[i];
      end else begin
        data_s[63-16*i -: 16] = 16'h0000;
      end
    end
  end

  always_comb begin
    int deq_n;
    int enq_n;
    int rem;
    buf_d   = buf_q;
    count_d = count_q;
    skip_d  = skip_q;
    pc_d    = pc_q;
    deq_n   = deq_s ? int'(head_n) : 0;
    enq_n   = enq_s ? (4 - int'(skip_q)) : 0;
    rem     = int'(count_q) - deq_n;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_d[i] = '0;
      end
      count_d = 5'd0;
      pc_d    = bus.flush_pc & ~64'd1;
      skip_d  = bus.flush_pc[2:1];
    end else begin
      // Survivors slide toward the head; the new word lands right behind them.
      for (int i = 0; i < DEPTH; i++) begin
        if (i < rem) begin
          buf_d[i] = buf_q[i + deq_n];
        end else if ((i - rem) < enq_n) begin
          buf_d[i] = word_parcel(bus.fetch_data, int'(skip_q) + i - rem);
        end else begin
          buf_d[i] = '0;
        end
      end
      count_d = 5'(rem + enq_n);
      if (enq_s) begin
        skip_d = 2'd0;
      end else begin
        skip_d = skip_q;
      end
      if (deq_s) begin
        pc_d = pc_q + {60'd0, head_n, 1'b0};
      end else begin
        pc_d = pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      count_q <= 5'd0;
      skip_q  <= 2'd0;
      pc_q    <= 64'd0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      skip_q  <= skip_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.fetch_ready = ready_s;
  assign bus.inst_valid  = valid_s && !rst;
  assign bus.inst_data   = rst ? 64'd0 : data_s;
  assign bus.inst_len    = rst ? 2'd0 : head_len;
  assign bus.inst_pc     = pc_q;
  assign bus.fill_level  = rst ? 5'd0 : count_q;

endmodule

// File: tb/tb_inst_align.sv
// Self-checking bench for inst_align: parcel-queue reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_inst_align;
  localparam int DEPTH = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_align_if bus ();

  inst_align #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mq[$];
  logic [63:0] m_pc;
  int          m_skip;
  int          errors = 0;
  int          checks = 0;

  logic        s_valid, s_rdy;
  logic [63:0] s_data, s_pc;
  logic [1:0]  s_len;
  logic [4:0]  s_fill;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected head view straight from the queue of held parcels.
  task automatic model_outs(output logic v, output logic [63:0] d, output logic [1:0] len,
                            output int n);
    n   = 1;
    len = 2'd0;
    if (mq.size() > 0) begin
      case (mq[0][15:14])
        2'b10:   begin n = 2; len = 2'd1; end
        2'b11:   begin n = 4; len = 2'd2; end
        default: begin n = 1; len = 2'd0; end
      endcase
    end
    v = (mq.size() >= n);
    d = 64'd0;
    for (int i = 0; i < n && i < mq.size(); i++) d[63-16*i -: 16] = mq[i];
  endtask

  task automatic step(input logic fv, input logic [63:0] fd, input logic fl,
                      input logic [63:0] fpc, input logic ir);
    logic ev, erdy;
    logic [63:0] ed;
    logic [1:0] el;
    int en;
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.flush       = fl;
    bus.flush_pc    = fpc;
    bus.inst_ready  = ir;
    @(negedge clk);
    s_valid = bus.inst_valid;
    s_rdy   = bus.fetch_ready;
    s_data  = bus.inst_data;
    s_pc    = bus.inst_pc;
    s_len   = bus.inst_len;
    s_fill  = bus.fill_level;
    model_outs(ev, ed, el, en);
    erdy = (mq.size() <= DEPTH - 4);
    if (rst) begin
      chk("rst_fetch_ready", 64'(s_rdy), 64'd0);
      chk("rst_inst_valid", 64'(s_valid), 64'd0);
      chk("rst_inst_data", s_data, 64'd0);
      chk("rst_inst_len", 64'(s_len), 64'd0);
      chk("rst_fill_level", 64'(s_fill), 64'd0);
      mq.delete();
      m_pc   = 64'd0;
      m_skip = 0;
    end else begin
      chk("fetch_ready", 64'(s_rdy), 64'(erdy));
      chk("inst_valid", 64'(s_valid), 64'(ev));
      chk("fill_level", 64'(s_fill), 64'(mq.size()));
      chk("inst_data", s_data, ed);
      if (ev) begin
        chk("inst_len", 64'(s_len), 64'(el));
        chk("inst_pc", s_pc, m_pc);
      end
      if (fl) begin
        mq.delete();
        m_pc   = fpc & ~64'd1;
        m_skip = int'(fpc[2:1]);
      end else begin
        if (ev && ir) begin
          repeat (en) void'(mq.pop_front());
          m_pc = m_pc + 64'(2 * en);
        end
        if (fv && erdy) begin
          for (int k = m_skip; k < 4; k++) mq.push_back(fd[63-16*k -: 16]);
          m_skip = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ir);
    step(1'b0, 64'd0, 1'b0, 64'd0, ir);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] w;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = 64'd0;
    bus.flush       = 1'b0;
    bus.flush_pc    = 64'd0;
    bus.inst_ready  = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Four 16b instructions from one word
    step(1'b1, 64'h0001_0002_0003_0004, 1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      chk("t1_valid", 64'(s_valid), 64'd1);
      chk("t1_data", s_data, {16'(i + 1), 48'd0});
      chk("t1_pc", s_pc, 64'(2 * i));
      chk("t1_len", 64'(s_len), 64'd0);
    end

    // 32b then a 64b instruction straddling two words
    do_reset();
    step(1'b1, 64'h8000_1111_C000_2222, 1'b0, 64'd0, 1'b1);
    idle(1'b1);
    chk("t2_32b_data", s_data, 64'h8000_1111_0000_0000);
    chk("t2_32b_len", 64'(s_len), 64'd1);
    chk("t2_32b_pc", s_pc, 64'd0);
    idle(1'b1);
    chk("t2_wait_valid", 64'(s_valid), 64'd0);
    chk("t2_partial", s_data, 64'hC000_2222_0000_0000);
    step(1'b1, 64'h3333_4444_0005_0006, 1'b0, 64'd0, 1'b1);
    idle(1'b1);
    chk("t2_64b_data", s_data, 64'hC000_2222_3333_4444);
    chk("t2_64b_len", 64'(s_len), 64'd2);
    chk("t2_64b_pc", s_pc, 64'd4);
    idle(1'b1);
    chk("t2_16a", s_data, 64'h0005_0000_0000_0000);
    chk("t2_16a_pc", s_pc, 64'd12);
    idle(1'b1);
    chk("t2_16b", s_data, 64'h0006_0000_0000_0000);

    // Back-pressure: fill until fetch_ready drops, then drain
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 64'h0101_0202_0303_0404 + 64'(i), 1'b0, 64'd0, 1'b0);
    chk("t3_full_ready", 64'(s_rdy), 64'd0);
    chk("t3_full_fill", 64'(s_fill), 64'd12);
    for (int i = 0; i < 14; i++) idle(1'b1);
    chk("t3_drained", 64'(s_fill), 64'd0);

    // Flush during simultaneous enqueue and dequeue
    do_reset();
    step(1'b1, 64'h0001_0002_0003_0004, 1'b0, 64'd0, 1'b1);
    step(1'b1, 64'h0009_0009_0009_0009, 1'b1, 64'h106, 1'b1);
    step(1'b1, 64'h1111_2222_3333_0044, 1'b0, 64'd0, 1'b0);
    chk("t4_empty", 64'(s_fill), 64'd0);
    idle(1'b1);
    chk("t4_fill", 64'(s_fill), 64'd1);
    chk("t4_data", s_data, 64'h0044_0000_0000_0000);
    chk("t4_pc", s_pc, 64'h106);

    // Enqueue plus 64b dequeue at count 8
    do_reset();
    step(1'b1, 64'hC000_0001_0002_0003, 1'b0, 64'd0, 1'b0);
    step(1'b1, 64'h0004_0005_0006_0007, 1'b0, 64'd0, 1'b0);
    step(1'b1, 64'h0008_0009_000A_000B, 1'b0, 64'd0, 1'b1);
    chk("t5_fill_before", 64'(s_fill), 64'd8);
    idle(1'b0);
    chk("t5_fill_after", 64'(s_fill), 64'd8);
    chk("t5_head", s_data, 64'h0004_0000_0000_0000);
    chk("t5_pc", s_pc, 64'd8);

    // PC wrap, then reset mid-stream
    do_reset();
    step(1'b0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    step(1'b1, 64'h1111_2222_3333_0033, 1'b0, 64'd0, 1'b0);
    idle(1'b1);
    chk("t6_pc_top", s_pc, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1'b1, 64'h0001_0002_0003_0004, 1'b0, 64'd0, 1'b0);
    chk("t6_pc_wrap", s_pc, 64'd0);
    rst = 1'b1;
    step(1'b1, 64'h0001_0002_0003_0004, 1'b1, 64'h40, 1'b1);
    step(1'b1, 64'h0001_0002_0003_0004, 1'b1, 64'h40, 1'b1);
    chk("t6_rst_valid", 64'(s_valid), 64'd0);
    chk("t6_rst_fill", 64'(s_fill), 64'd0);
    chk("t6_rst_data", s_data, 64'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      w = {$urandom, $urandom};
      if ($urandom_range(0, 99) < 2) begin
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      step(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 99) < 3),
           {$urandom, $urandom}, 1'($urandom_range(0, 2) != 0));
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
